// File: rtl/toy_btb_pkg.sv
// Shared types and helpers for the BTB update write path.
package toy_btb_pkg;

    localparam int unsigned BTB_ADDR_W  = 32;
    localparam int unsigned BTB_DATA_W  = 32;
    localparam int unsigned BTB_INDEX_W = 10;

    typedef struct packed {
        logic [BTB_INDEX_W-1:0] idx;
        logic [BTB_DATA_W-1:0]  data;
    } btb_upd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } btb_wr_state_e;

    // BTB index is the word-aligned PC truncated to the index width.
    function automatic logic [BTB_INDEX_W-1:0] btb_index(input logic [BTB_ADDR_W-1:0] pc);
        return BTB_INDEX_W'(pc >> 2);
    endfunction

endpackage

// File: rtl/toy_btb_upd_fifo.sv
// Coalescing update FIFO: at most one pending entry per BTB index, CAM lookup for bypass.
module toy_btb_upd_fifo #(
    parameter int unsigned INDEX_WIDTH = 10,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq,
    input  logic [INDEX_WIDTH-1:0]   enq_idx,
    input  logic [DATA_WIDTH-1:0]    enq_data,
    input  logic                     deq,
    input  logic [INDEX_WIDTH-1:0]   lkp_idx,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   cnt_nxt,
    output logic [INDEX_WIDTH-1:0]   head_idx,
    output logic [DATA_WIDTH-1:0]    head_data,
    output logic                     byp_hit,
    output logic [DATA_WIDTH-1:0]    byp_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]       vld_q;
    logic [INDEX_WIDTH-1:0] idx_q  [DEPTH];
    logic [DATA_WIDTH-1:0]  data_q [DEPTH];
    logic [PTR_W-1:0]       head_q;
    logic [PTR_W-1:0]       tail_q;
    logic [CNT_W-1:0]       cnt_q;

    logic [DEPTH-1:0]       upd_hit;
    logic [DEPTH-1:0]       lkp_hit;
    logic                   append;

    // Match vectors; a head that leaves this cycle cannot absorb a same-index update.
    always_comb begin
        upd_hit  = '0;
        lkp_hit  = '0;
        byp_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            upd_hit[i] = vld_q[i] && (idx_q[i] == enq_idx) && !(deq && (head_q == PTR_W'(i)));
            lkp_hit[i] = vld_q[i] && (idx_q[i] == lkp_idx);
            if (lkp_hit[i]) begin
                byp_data = byp_data | data_q[i];
            end
        end
    end

    assign append    = enq && !(|upd_hit);
    assign byp_hit   = |lkp_hit;
    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign count     = cnt_q;
    assign head_idx  = idx_q[head_q];
    assign head_data = data_q[head_q];
    assign cnt_nxt   = flush ? '0 : (cnt_q + CNT_W'(append) - CNT_W'(deq));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            vld_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (deq) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + PTR_W'(1);
            end
            if (append) begin
                vld_q[tail_q] <= 1'b1;
                tail_q        <= tail_q + PTR_W'(1);
            end
            cnt_q <= cnt_nxt;
        end
    end

    // Payload storage; validity is tracked separately so no reset is needed here.
    always_ff @(posedge clk) begin
        if (enq && !flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (upd_hit[i]) begin
                    data_q[i] <= enq_data;
                end
            end
            if (append) begin
                idx_q[tail_q]  <= enq_idx;
                data_q[tail_q] <= enq_data;
            end
        end
    end

endmodule

// File: rtl/toy_btb_update_writer.sv
// BTB write-side arbiter: queues backend updates and drains them through the shared memory port.
module toy_btb_update_writer
    import toy_btb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned INDEX_WIDTH  = 10,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     upd_vld,
    output logic                     upd_rdy,
    input  logic [ADDR_WIDTH-1:0]    upd_pc,
    input  logic [DATA_WIDTH-1:0]    upd_data,
    input  logic                     flush,
    input  logic                     lkp_vld,
    input  logic [ADDR_WIDTH-1:0]    lkp_pc,
    output logic                     lkp_stall,
    output logic                     byp_hit,
    output logic [DATA_WIDTH-1:0]    byp_data,
    output logic                     mem_en,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wr_data,
    output logic                     mem_wr_en,
    output logic [$clog2(DEPTH):0]   pend_cnt
);

    localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    btb_wr_state_e          state_q, state_d;
    logic [STARVE_W-1:0]    starve_q, starve_d;

    logic [INDEX_WIDTH-1:0] upd_idx;
    logic [INDEX_WIDTH-1:0] lkp_idx;
    logic                   enq;
    logic                   wr;
    logic                   blocked;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [INDEX_WIDTH-1:0] head_idx;
    logic [DATA_WIDTH-1:0]  head_data;
    logic                   unused_pc_bits;

    assign upd_idx        = upd_pc[INDEX_WIDTH+1:2];
    assign lkp_idx        = lkp_pc[INDEX_WIDTH+1:2];
    assign unused_pc_bits = ^{upd_pc[ADDR_WIDTH-1:INDEX_WIDTH+2], upd_pc[1:0],
                              lkp_pc[ADDR_WIDTH-1:INDEX_WIDTH+2], lkp_pc[1:0]};

    assign upd_rdy = !fifo_full;
    assign enq     = upd_vld && upd_rdy;
    assign wr      = mem_wr_en;

    toy_btb_upd_fifo #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH       (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .enq       (enq),
        .enq_idx   (upd_idx),
        .enq_data  (upd_data),
        .deq       (wr),
        .lkp_idx   (lkp_idx),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (pend_cnt),
        .cnt_nxt   (cnt_nxt),
        .head_idx  (head_idx),
        .head_data (head_data),
        .byp_hit   (byp_hit),
        .byp_data  (byp_data)
    );

    // Memory port mux: forced write, then lookup, then opportunistic drain.
    always_comb begin
        mem_en      = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        lkp_stall   = 1'b0;
        if (!rst) begin
            if ((state_q == FORCE) && !fifo_empty) begin
                mem_en      = 1'b1;
                mem_wr_en   = 1'b1;
                mem_addr    = ADDR_WIDTH'(head_idx);
                mem_wr_data = head_data;
                lkp_stall   = lkp_vld;
            end else if (lkp_vld) begin
                mem_en   = 1'b1;
                mem_addr = ADDR_WIDTH'(lkp_idx);
            end else if (!fifo_empty) begin
                mem_en      = 1'b1;
                mem_wr_en   = 1'b1;
                mem_addr    = ADDR_WIDTH'(head_idx);
                mem_wr_data = head_data;
            end
        end
    end

    assign blocked = (state_q == PEND) && lkp_vld;

    // Next state and starvation counter.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        unique case (state_q)
            IDLE: begin
                if (cnt_nxt != '0) state_d = PEND;
            end
            PEND: begin
                if (cnt_nxt == '0) begin
                    state_d = IDLE;
                end else if (blocked && (starve_q == STARVE_W'(STARVE_LIMIT - 1))) begin
                    state_d = FORCE;
                end
            end
            FORCE: begin
                state_d = (cnt_nxt == '0) ? IDLE : PEND;
            end
            default: state_d = IDLE;
        endcase

        if ((state_q != PEND) || wr) begin
            starve_d = '0;
        end else if (blocked) begin
            starve_d = (starve_q == STARVE_W'(STARVE_LIMIT - 1)) ? '0 : starve_q + STARVE_W'(1);
        end

        if (flush) begin
            state_d  = IDLE;
            starve_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_toy_btb_update_writer.sv
// Scoreboarded bench for toy_btb_update_writer: expected writes queued by stimulus, checked by a monitor.
module tb_toy_btb_update_writer;
    import toy_btb_pkg::*;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned IW    = 10;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SL    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          upd_vld;
    logic          upd_rdy;
    logic [AW-1:0] upd_pc;
    logic [DW-1:0] upd_data;
    logic          flush;
    logic          lkp_vld;
    logic [AW-1:0] lkp_pc;
    logic          lkp_stall;
    logic          byp_hit;
    logic [DW-1:0] byp_data;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_wr_en;
    logic [2:0]    pend_cnt;

    btb_upd_t exp_q[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    toy_btb_update_writer #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .INDEX_WIDTH  (IW),
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .upd_vld     (upd_vld),
        .upd_rdy     (upd_rdy),
        .upd_pc      (upd_pc),
        .upd_data    (upd_data),
        .flush       (flush),
        .lkp_vld     (lkp_vld),
        .lkp_pc      (lkp_pc),
        .lkp_stall   (lkp_stall),
        .byp_hit     (byp_hit),
        .byp_data    (byp_data),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_en   (mem_wr_en),
        .pend_cnt    (pend_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [IW-1:0] idx, input logic [DW-1:0] data);
        btb_upd_t e;
        e.idx  = idx;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write monitor: every write the DUT presents must match the next expected entry.
    always @(negedge clk) begin
        btb_upd_t e;
        if (mem_en === 1'b1 && mem_wr_en === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h, expected no write", mem_addr, mem_wr_data);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== AW'(e.idx) || mem_wr_data !== e.data) begin
                    bad++;
                    $display("FAIL write_payload: got addr=%0h data=%0h expected addr=%0h data=%0h",
                             mem_addr, mem_wr_data, AW'(e.idx), e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; upd_vld = 1'b0; upd_pc = '0; upd_data = '0;
        flush = 1'b0; lkp_vld = 1'b1; lkp_pc = 32'h1004;

        // Reset: port quiet even with a lookup requested
        @(negedge clk);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_lkp_stall", 64'(lkp_stall), 64'd0);
        chk("rst_byp_hit", 64'(byp_hit), 64'd0);
        tick(); rst = 1'b0; lkp_vld = 1'b0;
        @(negedge clk);
        chk("idle_mem_en", 64'(mem_en), 64'd0);
        chk("idle_upd_rdy", 64'(upd_rdy), 64'd1);
        chk("idle_pend_cnt", 64'(pend_cnt), 64'd0);
        tick();

        // Single update drains next cycle; a same-index update while the head leaves re-enqueues
        upd_vld = 1'b1; upd_pc = 32'h1004; upd_data = 32'hAA;
        push(10'h001, 32'hAA);
        @(negedge clk);
        chk("t2_no_write_yet", 64'(mem_en), 64'd0);
        tick(); upd_data = 32'hCC;
        push(10'h001, 32'hCC);
        @(negedge clk);
        chk("t2_pend_one", 64'(pend_cnt), 64'd1);
        chk("t2_wr_en", 64'(mem_wr_en), 64'd1);
        tick(); upd_vld = 1'b0;
        @(negedge clk);
        chk("t2_reenq_pend", 64'(pend_cnt), 64'd1);
        tick();
        @(negedge clk);
        chk("t2_drained", 64'(pend_cnt), 64'd0);
        chk("t2_mem_en_off", 64'(mem_en), 64'd0);
        tick();

        // Coalescing plus bypass
        lkp_vld = 1'b1; lkp_pc = 32'h1004;
        upd_vld = 1'b1; upd_pc = 32'h1004; upd_data = 32'hAA;
        tick(); upd_data = 32'hBB;
        tick(); upd_vld = 1'b0;
        @(negedge clk);
        chk("t3_pend_cnt", 64'(pend_cnt), 64'd1);
        chk("t3_byp_hit", 64'(byp_hit), 64'd1);
        chk("t3_byp_data", 64'(byp_data), 64'hBB);
        chk("t3_read", 64'(mem_wr_en), 64'd0);
        chk("t3_read_addr", 64'(mem_addr), 64'h1);
        lkp_pc = 32'h2000;
        #1;
        chk("t3_byp_miss", 64'(byp_hit), 64'd0);
        chk("t3_byp_miss_data", 64'(byp_data), 64'd0);
        tick(); lkp_vld = 1'b0;
        push(10'h001, 32'hBB);
        @(negedge clk);
        chk("t3_drain_wr", 64'(mem_wr_en), 64'd1);
        tick();
        @(negedge clk);
        chk("t3_empty", 64'(pend_cnt), 64'd0);
        tick();

        // Fill to DEPTH under lookups; 5th waits for a drain
        lkp_vld = 1'b1; lkp_pc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            upd_vld = 1'b1; upd_pc = 32'((i + 1) * 16); upd_data = 32'(i + 1);
            tick();
        end
        upd_pc = 32'h50; upd_data = 32'h5;
        push(10'd4, 32'h1); push(10'd8, 32'h2); push(10'd12, 32'h3);
        push(10'd16, 32'h4); push(10'd20, 32'h5);
        @(negedge clk);
        chk("t4_full_rdy", 64'(upd_rdy), 64'd0);
        chk("t4_full_cnt", 64'(pend_cnt), 64'd4);
        chk("t4_blocked", 64'(mem_wr_en), 64'd0);
        tick(); lkp_vld = 1'b0;
        @(negedge clk);
        chk("t4_still_full", 64'(upd_rdy), 64'd0);
        chk("t4_cnt_4", 64'(pend_cnt), 64'd4);
        tick();
        @(negedge clk);
        chk("t4_rdy_again", 64'(upd_rdy), 64'd1);
        chk("t4_cnt_3", 64'(pend_cnt), 64'd3);
        tick(); upd_vld = 1'b0;
        @(negedge clk);
        chk("t4_cnt_3_after_enq", 64'(pend_cnt), 64'd3);
        for (int k = 0; k < 20 && pend_cnt != 3'd0; k++) tick();
        @(negedge clk);
        chk("t4_drained", 64'(pend_cnt), 64'd0);
        tick();

        // Starvation guard forces a write on the ninth blocked cycle
        lkp_vld = 1'b1; lkp_pc = 32'h3000;
        upd_vld = 1'b1; upd_pc = 32'h2008; upd_data = 32'h55;
        tick(); upd_vld = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("t5_no_stall", 64'(lkp_stall), 64'd0);
            chk("t5_read_only", 64'(mem_wr_en), 64'd0);
            tick();
        end
        push(10'h002, 32'h55);
        @(negedge clk);
        chk("t5_force_stall", 64'(lkp_stall), 64'd1);
        chk("t5_force_wr", 64'(mem_wr_en), 64'd1);
        tick();
        @(negedge clk);
        chk("t5_stall_clear", 64'(lkp_stall), 64'd0);
        chk("t5_read_resumes", 64'(mem_en & ~mem_wr_en), 64'd1);
        chk("t5_empty", 64'(pend_cnt), 64'd0);
        tick(); lkp_vld = 1'b0;

        // Flush with pending entries and a same-cycle update; the same-cycle write still issues
        lkp_vld = 1'b1; lkp_pc = 32'h0;
        upd_vld = 1'b1; upd_pc = 32'h100; upd_data = 32'h11; tick();
        upd_pc = 32'h200; upd_data = 32'h22; tick();
        upd_pc = 32'h300; upd_data = 32'h33; tick();
        lkp_vld = 1'b0; flush = 1'b1; upd_pc = 32'h400; upd_data = 32'h44;
        push(10'h040, 32'h11);
        @(negedge clk);
        chk("t6_pend_3", 64'(pend_cnt), 64'd3);
        chk("t6_flush_wr", 64'(mem_wr_en), 64'd1);
        tick(); flush = 1'b0; upd_vld = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t6_flushed_cnt", 64'(pend_cnt), 64'd0);
            chk("t6_quiet", 64'(mem_en), 64'd0);
            tick();
        end

        // Async reset in the middle of a drain
        lkp_vld = 1'b1; lkp_pc = 32'h600;
        upd_vld = 1'b1; upd_pc = 32'h500; upd_data = 32'h66; tick();
        upd_pc = 32'h600; upd_data = 32'h77; tick();
        upd_vld = 1'b0; lkp_vld = 1'b0;
        push(10'h140, 32'h66);
        @(negedge clk);
        chk("t7_pend_2", 64'(pend_cnt), 64'd2);
        chk("t7_byp_before", 64'(byp_hit), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("t7_rst_mem_en", 64'(mem_en), 64'd0);
        chk("t7_rst_wr_en", 64'(mem_wr_en), 64'd0);
        chk("t7_rst_cnt", 64'(pend_cnt), 64'd0);
        chk("t7_rst_byp", 64'(byp_hit), 64'd0);
        tick(); lkp_vld = 1'b1;
        @(negedge clk);
        chk("t7_rst_lkp_quiet", 64'(mem_en), 64'd0);
        tick(); rst = 1'b0; lkp_vld = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t7_post_cnt", 64'(pend_cnt), 64'd0);
            chk("t7_post_quiet", 64'(mem_en), 64'd0);
            tick();
        end
        chk("t7_upd_rdy", 64'(upd_rdy), 64'd1);

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
